// File: rtl/booth_r4_pkg.sv
// Shared types and helpers for the sequential radix-4 approximate Booth multiplier.
package booth_r4_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Radix-4 Booth groups {y[2i+1], y[2i], y[2i-1]}
    localparam logic [2:0] BC_ZERO0 = 3'b000;
    localparam logic [2:0] BC_P1A   = 3'b001;
    localparam logic [2:0] BC_P1B   = 3'b010;
    localparam logic [2:0] BC_P2    = 3'b011;
    localparam logic [2:0] BC_N2    = 3'b100;
    localparam logic [2:0] BC_N1A   = 3'b101;
    localparam logic [2:0] BC_N1B   = 3'b110;
    localparam logic [2:0] BC_ZERO1 = 3'b111;

    function automatic int unsigned clamp_m(input int unsigned m, input int unsigned n);
        return (m > n) ? n : m;
    endfunction

endpackage

// File: rtl/booth_r4_approx_seq_pp_gen.sv
// Combinational Booth partial-product generator; the low m bits treat 2A as A.
module booth_r4_pp_gen
    import booth_r4_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned MW = 4
) (
    input  logic [2:0]    grp,
    input  logic [N+1:0]  xe,
    input  logic [MW-1:0] m,
    output logic [N+1:0]  pp_c
);
    localparam int unsigned PW = N + 2;

    logic          zero;
    logic          neg;
    logic          two;
    logic [PW-1:0] xe_sh;
    logic [PW-1:0] raw;

    always_comb begin
        zero = 1'b0;
        neg  = 1'b0;
        two  = 1'b0;
        case (grp)
            BC_P1A, BC_P1B: zero = 1'b0;
            BC_P2:          two  = 1'b1;
            BC_N2: begin
                two = 1'b1;
                neg = 1'b1;
            end
            BC_N1A, BC_N1B: neg  = 1'b1;
            default:        zero = 1'b1;
        endcase
    end

    // xe_sh[t] is xe[t-1] with xe[-1] = 0
    assign xe_sh = xe << 1;

    always_comb begin
        raw = '0;
        for (int unsigned t = 0; t <= N; t++) begin
            if (MW'(t) < m)
                raw[t] = (~xe[t] & neg) | (xe[t] & ~neg & ~zero);
            else
                raw[t] = ~zero & (neg ^ (two ? xe_sh[t] : xe[t]));
        end
        raw[PW-1] = neg;
        // Exact mode completes the two's complement; approximate mode just sets the LSB
        if (m == '0)
            pp_c = raw + PW'(neg);
        else
            pp_c = raw | PW'(neg);
    end

endmodule

// File: rtl/booth_r4_approx_seq.sv
// Sequential radix-4 approximate Booth multiplier: one partial product accumulated per clock.
module booth_r4_approx_seq
    import booth_r4_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned MW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    x,
    input  logic [N-1:0]    y,
    input  logic [MW-1:0]   approx_m,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  p,
    output logic            busy
);
    localparam int unsigned K      = N / 2;
    localparam int unsigned PW     = N + 2;
    localparam int unsigned PROD_W = 2 * N;
    localparam int unsigned CW     = $clog2(K + 2);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic [N-1:0]        x_q, x_d;
    logic [N-1:0]        y_q, y_d;
    logic [MW-1:0]       m_q, m_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic [N+2:0]        ye;
    logic [2:0]          grp;
    logic [PW-1:0]       xe;
    logic [PW-1:0]       pp;
    logic [PROD_W-1:0]   pp_ext;

    // ye[2i+2:2i] is group i; the two zero MSBs give the final {0,0,y[N-1]} group
    assign ye     = {2'b00, y_q, 1'b0};
    assign grp    = 3'(ye >> {cnt_q, 1'b0});
    assign xe     = {2'b00, x_q};
    assign pp_ext = {{(PROD_W - PW){pp[PW-1]}}, pp};

    booth_r4_pp_gen #(.N(N), .MW(MW)) u_pp_gen (
        .grp  (grp),
        .xe   (xe),
        .m    (m_q),
        .pp_c (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            m_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            x_q         <= x_d;
            y_q         <= y_d;
            m_q         <= m_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        p_d         = p_q;
        x_d         = x_q;
        y_d         = y_q;
        m_d         = m_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = RUN;
                    x_d     = x;
                    y_d     = y;
                    m_d     = MW'(clamp_m(32'(approx_m), N));
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // K+1 accumulate cycles, then one cycle to publish the product
                if (cnt_q == CW'(K + 1)) begin
                    p_d         = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d = acc_q + (pp_ext << {cnt_q, 1'b0});
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == RUN);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule
